// File: rtl/harvard_data_mem_responder.sv
// Memory-side responder for the CPU data port. Reads are combinational and writes take one cycle.
// After reset, a zero-fill sweep runs before accesses are served. It also keeps sticky error flags and saturating counters.
module harvard_data_mem_responder #(
  parameter logic [31:0] BASE  = 32'h0000_0000,
  parameter int          WORDS = 1024,
  parameter int          CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_enable,
  input  logic [31:0]      data_address,
  input  logic             data_write,
  input  logic             data_read,
  input  logic [31:0]      data_writedata,
  output logic [31:0]      data_readdata,
  output logic             ready,
  output logic             err_range,
  output logic             err_conflict,
  output logic [CNT_W-1:0] read_count,
  output logic [CNT_W-1:0] write_count
);

  localparam int AW = $clog2(WORDS);

  typedef enum logic {CLEAR, READY} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] clr_idx, clr_idx_nxt;
  logic [31:0]   mem [WORDS];

  // Decode in 33 bits so a window ending at 2^32 cannot wrap.
  logic [32:0]   addr_ext, lo_ext, hi_ext;
  logic          hit;
  logic [31:0]   offset;
  logic [AW-1:0] idx;
  logic          unused_offset_bits;
  logic          acc, wr_ok, rd_ok;

  assign addr_ext = {1'b0, data_address};
  assign lo_ext   = {1'b0, BASE};
  assign hi_ext   = lo_ext + (33'(WORDS) << 2);
  assign hit      = (addr_ext >= lo_ext) && (addr_ext < hi_ext);
  assign offset   = data_address - BASE;
  assign idx      = offset[AW+1:2];
  assign unused_offset_bits = &{1'b0, offset[31:AW+2], offset[1:0]};

  assign ready = (state == READY);
  assign acc   = ready && clk_enable;
  assign wr_ok = acc && data_write && hit;
  assign rd_ok = acc && data_read && hit;

  assign data_readdata = (ready && data_read && hit) ? mem[idx] : 32'h0;

  always_comb begin
    state_nxt   = state;
    clr_idx_nxt = clr_idx;
    case (state)
      CLEAR: begin
        clr_idx_nxt = clr_idx + 1'b1;
        if (clr_idx == AW'(WORDS - 1)) state_nxt = READY;
      end
      READY: state_nxt = READY;
      default: state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= CLEAR;
      clr_idx <= '0;
    end else begin
      state   <= state_nxt;
      clr_idx <= clr_idx_nxt;
    end
  end

  // The sweep owns the array until it finishes, so CPU writes are dropped in CLEAR.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == CLEAR) mem[clr_idx] <= 32'h0;
      else if (wr_ok)     mem[idx]     <= data_writedata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      read_count   <= '0;
      write_count  <= '0;
      err_range    <= 1'b0;
      err_conflict <= 1'b0;
    end else begin
      if (rd_ok && (read_count != {CNT_W{1'b1}}))  read_count  <= read_count + 1'b1;
      if (wr_ok && (write_count != {CNT_W{1'b1}})) write_count <= write_count + 1'b1;
      if (acc && (data_read || data_write) && !hit) err_range    <= 1'b1;
      if (acc && data_read && data_write)            err_conflict <= 1'b1;
    end
  end

endmodule

// File: tb/tb_harvard_data_mem_responder.sv
// Directed bench for harvard_data_mem_responder with a cycle-level reference model and literal spot checks.
module tb_harvard_data_mem_responder;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          WORDS = 16;
  localparam int          CNT_W = 2;
  localparam int          CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             clk_enable = 1'b0;
  logic [31:0]      data_address = 32'h0;
  logic             data_write = 1'b0;
  logic             data_read = 1'b0;
  logic [31:0]      data_writedata = 32'h0;
  logic [31:0]      data_readdata;
  logic             ready;
  logic             err_range;
  logic             err_conflict;
  logic [CNT_W-1:0] read_count;
  logic [CNT_W-1:0] write_count;

  harvard_data_mem_responder #(.BASE(BASE), .WORDS(WORDS), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable),
    .data_address(data_address), .data_write(data_write), .data_read(data_read),
    .data_writedata(data_writedata), .data_readdata(data_readdata), .ready(ready),
    .err_range(err_range), .err_conflict(err_conflict),
    .read_count(read_count), .write_count(write_count)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: the sweep is a count of non-reset cycles, memory is a plain array.
  bit          started = 0;
  int          sweep = 0;
  logic [31:0] m_mem [WORDS];
  int          m_rc = 0, m_wc = 0;
  bit          m_er = 0, m_ec = 0;

  function automatic bit m_hit(input logic [31:0] a);
    longint la = longint'(a);
    return (la >= longint'(BASE)) && (la < longint'(BASE) + 4 * WORDS);
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    return int'((longint'(a) - longint'(BASE)) / 4);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      started = 1;
      sweep   = 0;
      for (int i = 0; i < WORDS; i++) m_mem[i] = 32'h0;
      m_rc = 0; m_wc = 0; m_er = 0; m_ec = 0;
    end else if (started) begin
      if (sweep < WORDS) sweep++;
      else if (clk_enable) begin
        if ((data_read || data_write) && !m_hit(data_address)) m_er = 1;
        if (data_read && data_write) m_ec = 1;
        if (m_hit(data_address)) begin
          if (data_read && m_rc < CMAX) m_rc++;
          if (data_write && m_wc < CMAX) m_wc++;
          if (data_write) m_mem[m_idx(data_address)] = data_writedata;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      logic [31:0] exp_rd;
      bit          m_rdy;
      m_rdy  = (sweep >= WORDS);
      exp_rd = (m_rdy && data_read && m_hit(data_address)) ? m_mem[m_idx(data_address)] : 32'h0;
      check("model_readdata", data_readdata, exp_rd);
      check("model_ready", 32'(ready), 32'(m_rdy));
      check("model_err_range", 32'(err_range), 32'(m_er));
      check("model_err_conflict", 32'(err_conflict), 32'(m_ec));
      check("model_read_count", 32'(read_count), 32'(m_rc));
      check("model_write_count", 32'(write_count), 32'(m_wc));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    data_read = 1'b0;
    data_write = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 200) begin
      n++;
      tick();
    end
  endtask

  task automatic read_at(input string name, input logic [31:0] a, input logic [31:0] exp);
    data_address = a;
    data_read = 1'b1;
    #1 check(name, data_readdata, exp);
    tick();
    data_read = 1'b0;
  endtask

  initial begin
    int n;
    clk_enable = 1'b1;

    // 1: sweep length and cleared contents
    do_reset();
    check("reset_ready", 32'(ready), 32'h0);
    check("reset_read_count", 32'(read_count), 32'h0);
    wait_ready(n);
    check("sweep_cycles", 32'(n), 32'(WORDS));
    read_at("clear_word0", BASE, 32'h0);
    read_at("clear_wordlast", BASE + 4 * (WORDS - 1), 32'h0);

    // 2: write then read with low address bits ignored
    do_reset();
    wait_ready(n);
    data_address = BASE + 8; data_writedata = 32'hDEADBEEF; data_write = 1'b1;
    tick();
    idle();
    read_at("rd_base8", BASE + 8, 32'hDEADBEEF);
    read_at("rd_base10", BASE + 10, 32'hDEADBEEF);
    check("t2_write_count", 32'(write_count), 32'd1);
    check("t2_read_count", 32'(read_count), 32'd2);

    // 4: out-of-range accesses leave memory and counters alone
    data_address = BASE + 4 * WORDS; data_writedata = 32'hCAFE0001; data_write = 1'b1;
    tick();
    data_address = BASE - 4; data_writedata = 32'hCAFE0002;
    tick();
    idle();
    read_at("oor_rd_hi", BASE + 4 * WORDS, 32'h0);
    read_at("oor_rd_lo", BASE - 4, 32'h0);
    check("oor_err_range", 32'(err_range), 32'h1);
    check("oor_write_count", 32'(write_count), 32'd1);
    check("oor_read_count", 32'(read_count), 32'd2);
    read_at("oor_alias0", BASE, 32'h0);
    read_at("oor_alias_last", BASE + 4 * (WORDS - 1), 32'h0);

    // 3: simultaneous read and write of one word
    do_reset();
    wait_ready(n);
    check("post_reset_err_range", 32'(err_range), 32'h0);
    data_address = BASE + 4; data_writedata = 32'h12345678;
    data_read = 1'b1; data_write = 1'b1;
    #1 check("conflict_old_data", data_readdata, 32'h0);
    tick();
    data_write = 1'b0;
    #1 check("conflict_new_data", data_readdata, 32'h12345678);
    data_read = 1'b0;
    check("conflict_err", 32'(err_conflict), 32'h1);
    check("conflict_read_count", 32'(read_count), 32'd1);
    check("conflict_write_count", 32'(write_count), 32'd1);

    // 5: reset mid-sweep with a write pending
    do_reset();
    data_address = BASE + 12; data_writedata = 32'hAAAA5555; data_write = 1'b1;
    for (int i = 0; i < WORDS / 2 - 1; i++) tick();
    check("midsweep_not_ready", 32'(ready), 32'h0);
    do_reset();
    wait_ready(n);
    idle();
    check("resweep_cycles", 32'(n), 32'(WORDS));
    read_at("dropped_write", BASE + 12, 32'h0);

    // 6: clk_enable gating and counter saturation
    do_reset();
    wait_ready(n);
    clk_enable = 1'b0;
    data_address = BASE + 20; data_writedata = 32'h00000055; data_write = 1'b1;
    tick();
    tick();
    idle();
    check("gated_write_count", 32'(write_count), 32'd0);
    clk_enable = 1'b1;
    for (int i = 0; i < 5; i++) read_at("gated_no_write", BASE + 20, 32'h0);
    check("sat_read_count", 32'(read_count), 32'(CMAX));
    check("sat_write_count", 32'(write_count), 32'd0);

    tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
